// File: rtl/lcd_pkg.sv
// Shared definitions for the 8080-style LCD write-bus master: state encoding,
// idle levels of the active-low strobes and the default timing set.
package lcd_pkg;

  typedef enum logic [2:0] {
    ST_RST_LOW  = 3'd0,
    ST_RST_WAIT = 3'd1,
    ST_IDLE     = 3'd2,
    ST_SETUP    = 3'd3,
    ST_STROBE   = 3'd4,
    ST_HOLD     = 3'd5
  } lcd_state_e;

  localparam logic LCD_IDLE_CS = 1'b1;
  localparam logic LCD_IDLE_WR = 1'b1;
  localparam logic LCD_IDLE_RD = 1'b1;

  localparam int LCD_DATA_W = 24;

  localparam int DEF_T_SETUP    = 1;
  localparam int DEF_T_WR_LOW   = 2;
  localparam int DEF_T_HOLD     = 1;
  localparam int DEF_T_RST_LOW  = 500;
  localparam int DEF_T_RST_WAIT = 6000000;
  localparam int DEF_CNT_W      = 23;

  function automatic logic in_transfer(input lcd_state_e s);
    return (s == ST_SETUP) || (s == ST_STROBE) || (s == ST_HOLD);
  endfunction

  function automatic logic in_panel_reset(input lcd_state_e s);
    return (s == ST_RST_LOW) || (s == ST_RST_WAIT);
  endfunction

endpackage

// File: rtl/lcd_bus_wr_ctrl.sv
// Write-only 8080 LCD bus master: panel reset sequencing, timed cs/rs/wr
// strobes with back-to-back bursts, and a registered backlight enable.
module lcd_bus_wr_ctrl
  import lcd_pkg::*;
#(
  parameter int T_SETUP    = DEF_T_SETUP,
  parameter int T_WR_LOW   = DEF_T_WR_LOW,
  parameter int T_HOLD     = DEF_T_HOLD,
  parameter int T_RST_LOW  = DEF_T_RST_LOW,
  parameter int T_RST_WAIT = DEF_T_RST_WAIT,
  parameter int CNT_W      = DEF_CNT_W
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic                  i_is_data,
  input  logic [LCD_DATA_W-1:0] i_word,
  input  logic                  i_lcd_reset,
  input  logic                  i_blk_en,
  output logic                  o_busy,
  output logic                  o_blk,
  output logic                  o_cs,
  output logic                  o_rs,
  output logic                  o_wr,
  output logic                  o_rd,
  output logic                  o_rst,
  output logic [LCD_DATA_W-1:0] o_data
);

  localparam int T_MAX_A = (T_SETUP > T_WR_LOW) ? T_SETUP : T_WR_LOW;
  localparam int T_MAX_B = (T_HOLD > T_RST_LOW) ? T_HOLD : T_RST_LOW;
  localparam int T_MAX_C = (T_MAX_A > T_MAX_B) ? T_MAX_A : T_MAX_B;
  localparam int T_MAX   = (T_MAX_C > T_RST_WAIT) ? T_MAX_C : T_RST_WAIT;
  localparam longint CNT_SPAN = longint'(1) << CNT_W;

  if (T_SETUP < 1 || T_WR_LOW < 1 || T_HOLD < 1 || T_RST_LOW < 1 || T_RST_WAIT < 1) begin : g_bad_min
    $error("lcd_bus_wr_ctrl: every timing parameter must be at least 1");
  end
  if (longint'(T_MAX) > CNT_SPAN) begin : g_bad_width
    $error("lcd_bus_wr_ctrl: CNT_W too narrow for the largest timing parameter");
  end

  lcd_state_e            state, state_nx;
  logic [CNT_W-1:0]      cnt, cnt_nx, cnt_cur;
  logic                  fresh;
  logic                  pend, pend_nx;
  logic                  accept, last;
  logic                  ready_nx, busy_nx, cs_nx, wr_nx, rs_nx, rst_nx;
  logic [LCD_DATA_W-1:0] data_nx;

  function automatic logic [CNT_W-1:0] load_val(input lcd_state_e s);
    logic [CNT_W-1:0] v;
    v = '0;
    case (s)
      ST_RST_LOW:  v = CNT_W'(T_RST_LOW - 1);
      ST_RST_WAIT: v = CNT_W'(T_RST_WAIT - 1);
      ST_SETUP:    v = CNT_W'(T_SETUP - 1);
      ST_STROBE:   v = CNT_W'(T_WR_LOW - 1);
      ST_HOLD:     v = CNT_W'(T_HOLD - 1);
      default:     v = '0;
    endcase
    return v;
  endfunction

  // Reset leaves the counter at zero; the first RST_LOW cycle after release
  // behaves as a fresh entry so the pulse still lasts T_RST_LOW cycles.
  assign cnt_cur = fresh ? load_val(ST_RST_LOW) : cnt;
  assign last    = (cnt_cur == '0);
  assign accept  = i_valid & o_ready;

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt_cur;
    pend_nx  = pend;
    data_nx  = o_data;
    rs_nx    = o_rs;

    if (accept) begin
      data_nx = i_word;
      rs_nx   = i_is_data;
    end

    if (i_lcd_reset && !in_panel_reset(state)) begin
      pend_nx = 1'b1;
    end

    case (state)
      ST_RST_LOW:  if (last) state_nx = ST_RST_WAIT;
      ST_RST_WAIT: if (last) state_nx = ST_IDLE;
      ST_IDLE: begin
        if (accept)    state_nx = ST_SETUP;
        else if (pend) state_nx = ST_RST_LOW;
      end
      ST_SETUP:    if (last) state_nx = ST_STROBE;
      ST_STROBE:   if (last) state_nx = ST_HOLD;
      ST_HOLD: begin
        if (last) begin
          if (accept)    state_nx = ST_SETUP;
          else if (pend) state_nx = ST_RST_LOW;
          else           state_nx = ST_IDLE;
        end
      end
      default:     state_nx = ST_RST_LOW;
    endcase

    if (state_nx != state) begin
      cnt_nx = load_val(state_nx);
    end else if (!last) begin
      cnt_nx = cnt_cur - CNT_W'(1);
    end

    // The pending request is consumed by the reset sequence it triggers.
    if (state_nx == ST_RST_LOW && state != ST_RST_LOW) begin
      pend_nx = 1'b0;
    end

    ready_nx = !pend_nx && ((state_nx == ST_IDLE) ||
                            (state_nx == ST_HOLD && cnt_nx == '0));
    busy_nx  = (state_nx != ST_IDLE);
    cs_nx    = in_transfer(state_nx) ? 1'b0 : LCD_IDLE_CS;
    wr_nx    = (state_nx == ST_STROBE) ? 1'b0 : LCD_IDLE_WR;
    rst_nx   = (state_nx != ST_RST_LOW);
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state   <= ST_RST_LOW;
      cnt     <= '0;
      fresh   <= 1'b1;
      pend    <= 1'b0;
      o_ready <= 1'b0;
      o_busy  <= 1'b1;
      o_cs    <= LCD_IDLE_CS;
      o_wr    <= LCD_IDLE_WR;
      o_rd    <= LCD_IDLE_RD;
      o_rs    <= 1'b0;
      o_rst   <= 1'b0;
      o_data  <= '0;
      o_blk   <= 1'b0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      fresh   <= 1'b0;
      pend    <= pend_nx;
      o_ready <= ready_nx;
      o_busy  <= busy_nx;
      o_cs    <= cs_nx;
      o_wr    <= wr_nx;
      o_rd    <= LCD_IDLE_RD;
      o_rs    <= rs_nx;
      o_rst   <= rst_nx;
      o_data  <= data_nx;
      o_blk   <= i_blk_en;
    end
  end

endmodule

// File: tb/tb_lcd_bus_wr_ctrl.sv
// Directed bench for lcd_bus_wr_ctrl with a shortened panel reset (4 low, 8 wait);
// outputs are sampled and inputs driven on the falling clock edge.
module tb_lcd_bus_wr_ctrl;

  logic        clk = 1'b0;
  logic        reset, valid, is_data, lcd_reset, blk_en;
  logic [23:0] word;
  logic        ready, busy, blk, cs, rs, wr, rd, rst;
  logic [23:0] data;
  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;

  lcd_bus_wr_ctrl #(
    .T_RST_LOW (4),
    .T_RST_WAIT(8)
  ) dut (
    .i_clk      (clk),
    .i_reset    (reset),
    .i_valid    (valid),
    .o_ready    (ready),
    .i_is_data  (is_data),
    .i_word     (word),
    .i_lcd_reset(lcd_reset),
    .i_blk_en   (blk_en),
    .o_busy     (busy),
    .o_blk      (blk),
    .o_cs       (cs),
    .o_rs       (rs),
    .o_wr       (wr),
    .o_rd       (rd),
    .o_rst      (rst),
    .o_data     (data)
  );

  task automatic test_reset();
    int  low_cnt, high_cnt;
    logic ctl_ok;
    reset = 1'b1; valid = 1'b0; is_data = 1'b0; lcd_reset = 1'b0; blk_en = 1'b0; word = '0;
    repeat (3) @(negedge clk);
    total++;
    if ({cs, wr, rd, rs, rst, blk, ready, busy} !== 8'b1110_0001) begin
      bad++; $display("[TB] FAIL reset_ctl got=%b want=%b", {cs, wr, rd, rs, rst, blk, ready, busy}, 8'b1110_0001);
    end
    total++;
    if (data !== 24'h0) begin
      bad++; $display("[TB] FAIL reset_data got=%h want=000000", data);
    end
    reset = 1'b0;
    low_cnt = 0; high_cnt = 0; ctl_ok = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (rst !== 1'b0) break;
      if (cs !== 1'b1 || wr !== 1'b1 || ready !== 1'b0) ctl_ok = 1'b0;
      low_cnt++;
      @(negedge clk);
    end
    for (int i = 0; i < 30; i++) begin
      if (ready === 1'b1) break;
      if (rst !== 1'b1 || cs !== 1'b1 || wr !== 1'b1) ctl_ok = 1'b0;
      high_cnt++;
      @(negedge clk);
    end
    total++;
    if (low_cnt != 4) begin
      bad++; $display("[TB] FAIL rst_low_cycles got=%0d want=4", low_cnt);
    end
    total++;
    if (high_cnt != 8) begin
      bad++; $display("[TB] FAIL rst_wait_cycles got=%0d want=8", high_cnt);
    end
    total++;
    if (ctl_ok !== 1'b1) begin
      bad++; $display("[TB] FAIL rst_seq_ctl got=%b want=1", ctl_ok);
    end
    total++;
    if (ready !== 1'b1 || busy !== 1'b0) begin
      bad++; $display("[TB] FAIL rst_ready got=%b%b want=10", ready, busy);
    end
  endtask

  task automatic test_single_cmd();
    logic [4:0] cs_exp, wr_exp, ready_exp, busy_exp;
    cs_exp = 5'b10000; wr_exp = 5'b11001; ready_exp = 5'b11000; busy_exp = 5'b01111;
    valid = 1'b1; is_data = 1'b0; word = 24'h00002C;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      total++;
      if (cs !== cs_exp[c] || wr !== wr_exp[c]) begin
        bad++; $display("[TB] FAIL single_strobe c=%0d got cs=%b wr=%b want cs=%b wr=%b", c + 1, cs, wr, cs_exp[c], wr_exp[c]);
      end
      total++;
      if (ready !== ready_exp[c] || busy !== busy_exp[c]) begin
        bad++; $display("[TB] FAIL single_hs c=%0d got rdy=%b busy=%b want rdy=%b busy=%b", c + 1, ready, busy, ready_exp[c], busy_exp[c]);
      end
      total++;
      if (data !== 24'h00002C || rs !== 1'b0) begin
        bad++; $display("[TB] FAIL single_data c=%0d got %h rs=%b want 00002c rs=0", c + 1, data, rs);
      end
      if (c == 0) valid = 1'b0;
    end
  endtask

  task automatic test_back_to_back();
    logic [23:0] words [3];
    logic [23:0] exp_data;
    logic        exp_cs, exp_wr, prev_wr;
    int          idx, phase, cs_low, wr_falls;
    words[0] = 24'h111111; words[1] = 24'h222222; words[2] = 24'h333333;
    cs_low = 0; wr_falls = 0; prev_wr = 1'b1;
    valid = 1'b1; is_data = 1'b1; word = words[0];
    for (int c = 1; c <= 13; c++) begin
      @(negedge clk);
      idx = (c - 1) / 4; if (idx > 2) idx = 2;
      phase = (c - 1) % 4;
      exp_cs = (c <= 12) ? 1'b0 : 1'b1;
      exp_wr = (c <= 12 && (phase == 1 || phase == 2)) ? 1'b0 : 1'b1;
      exp_data = words[idx];
      total++;
      if (cs !== exp_cs || wr !== exp_wr) begin
        bad++; $display("[TB] FAIL burst_strobe c=%0d got cs=%b wr=%b want cs=%b wr=%b", c, cs, wr, exp_cs, exp_wr);
      end
      total++;
      if (data !== exp_data || rs !== 1'b1) begin
        bad++; $display("[TB] FAIL burst_data c=%0d got %h rs=%b want %h rs=1", c, data, rs, exp_data);
      end
      if (cs === 1'b0) cs_low++;
      if (prev_wr === 1'b1 && wr === 1'b0) wr_falls++;
      prev_wr = wr;
      if (c == 1) word = words[1];
      if (c == 5) word = words[2];
      if (c == 9) valid = 1'b0;
    end
    total++;
    if (cs_low != 12 || wr_falls != 3) begin
      bad++; $display("[TB] FAIL burst_counts got cs_low=%0d wr_pulses=%0d want 12 3", cs_low, wr_falls);
    end
  endtask

  task automatic test_lcd_reset_mid();
    logic        exp_cs, exp_wr, exp_rst, exp_ready;
    logic [23:0] exp_data;
    valid = 1'b1; is_data = 1'b1; word = 24'hABCDEF;
    for (int c = 1; c <= 18; c++) begin
      @(negedge clk);
      exp_cs    = (c <= 4 || c == 18) ? 1'b0 : 1'b1;
      exp_wr    = (c == 2 || c == 3) ? 1'b0 : 1'b1;
      exp_rst   = (c >= 5 && c <= 8) ? 1'b0 : 1'b1;
      exp_ready = (c == 17) ? 1'b1 : 1'b0;
      exp_data  = (c == 18) ? 24'h555555 : 24'hABCDEF;
      total++;
      if (cs !== exp_cs || wr !== exp_wr || rst !== exp_rst) begin
        bad++; $display("[TB] FAIL lcdrst_ctl c=%0d got cs=%b wr=%b rst=%b want cs=%b wr=%b rst=%b", c, cs, wr, rst, exp_cs, exp_wr, exp_rst);
      end
      total++;
      if (ready !== exp_ready || data !== exp_data) begin
        bad++; $display("[TB] FAIL lcdrst_accept c=%0d got rdy=%b data=%h want rdy=%b data=%h", c, ready, data, exp_ready, exp_data);
      end
      if (c == 1) word = 24'h555555;
      if (c == 2) lcd_reset = 1'b1;
      if (c == 3) lcd_reset = 1'b0;
      if (c == 18) valid = 1'b0;
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (busy === 1'b0) break;
    end
    total++;
    if (busy !== 1'b0 || ready !== 1'b1) begin
      bad++; $display("[TB] FAIL lcdrst_drain got busy=%b rdy=%b want 0 1", busy, ready);
    end
  endtask

  task automatic test_abort();
    valid = 1'b1; is_data = 1'b1; word = 24'h0F0F0F;
    @(negedge clk);
    valid = 1'b0;
    @(negedge clk);
    total++;
    if (wr !== 1'b0 || cs !== 1'b0) begin
      bad++; $display("[TB] FAIL abort_pre got cs=%b wr=%b want 0 0", cs, wr);
    end
    reset = 1'b1;
    @(negedge clk);
    total++;
    if ({wr, cs, rst, ready, busy, rs} !== 6'b110010) begin
      bad++; $display("[TB] FAIL abort_ctl got=%b want=110010", {wr, cs, rst, ready, busy, rs});
    end
    total++;
    if (data !== 24'h0) begin
      bad++; $display("[TB] FAIL abort_data got=%h want=000000", data);
    end
    reset = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ready === 1'b1) break;
    end
    total++;
    if (ready !== 1'b1) begin
      bad++; $display("[TB] FAIL abort_recover got rdy=%b want 1", ready);
    end
  endtask

  task automatic test_backlight();
    blk_en = 1'b1;
    total++;
    if (blk !== 1'b0 || rd !== 1'b1) begin
      bad++; $display("[TB] FAIL blk_before got blk=%b rd=%b want 0 1", blk, rd);
    end
    @(negedge clk);
    total++;
    if (blk !== 1'b1 || rd !== 1'b1) begin
      bad++; $display("[TB] FAIL blk_on got blk=%b rd=%b want 1 1", blk, rd);
    end
    blk_en = 1'b0;
    total++;
    if (blk !== 1'b1) begin
      bad++; $display("[TB] FAIL blk_hold got blk=%b want 1", blk);
    end
    @(negedge clk);
    total++;
    if (blk !== 1'b0 || rd !== 1'b1) begin
      bad++; $display("[TB] FAIL blk_off got blk=%b rd=%b want 0 1", blk, rd);
    end
  endtask

  initial begin
    test_reset();
    test_single_cmd();
    test_back_to_back();
    test_lcd_reset_mid();
    test_abort();
    test_backlight();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
